mux_rr_nx1: RTL and testbench

- Parametrised N-to-1 multiplexer with one registered output stage and valid/ready handshakes on every input channel and on the output.
- Two modes: manual, where an external select picks the channel, and round-robin, where valid channels are served fairly in turn.
- Successor to the 2x1 gate-level multiplexer. Sits between several producers and one consumer, for example a bus funnel or test-stimulus merger.

---
 rtl/mux_rr_nx1.sv | 120 ++++++++++++
 tb/tb_mux_rr_nx1.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N-to-1 valid/ready mux, manual select or round-robin; MUX_PKT_LOCK_EN adds packet lock.
// Latency: 1 cycle from input transfer to out_valid; sustains 1 beat/cycle.
// Backpressure: out_valid && !out_ready holds the output register and drops every in_ready.
module mux_rr_nx1 #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
`ifdef MUX_PKT_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last,
`endif
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] rr_g;
    logic             rr_hit;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic [WIDTH-1:0] grant_dat;
    logic             load_en;
    logic             xfer;
`ifdef MUX_PKT_LOCK_EN
    logic             lock;
    logic [SEL_W-1:0] lock_ch;
`endif

    // Walk farthest-to-nearest so the first valid channel after ptr wins.
    always_comb begin
        rr_hit = 1'b0;
        rr_g   = '0;
        rr_idx = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            rr_idx = SEL_W'((int'(ptr) + i) % CHANNELS);
            if (in_valid[rr_idx]) begin
                rr_hit = 1'b1;
                rr_g   = rr_idx;
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        if (!mode) begin
            if (int'(sel) < CHANNELS) begin
                grant_vld = in_valid[sel];
                grant     = sel;
            end
        end
`ifdef MUX_PKT_LOCK_EN
        else if (lock) begin
            grant_vld = in_valid[lock_ch];
            grant     = lock_ch;
        end
`endif
        else begin
            grant_vld = rr_hit;
            grant     = rr_g;
        end
    end

    assign load_en = !rst && (!out_valid || out_ready);
    assign xfer    = load_en && grant_vld;

    always_comb begin
        in_ready  = '0;
        grant_dat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant == SEL_W'(k)) begin
                in_ready[k] = xfer;
                grant_dat   = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SEL_W'(CHANNELS - 1);
`ifdef MUX_PKT_LOCK_EN
            out_last  <= 1'b0;
            lock      <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (load_en) begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_data <= grant_dat;
                out_ch   <= grant;
                if (mode) begin
                    ptr <= grant;
                end
`ifdef MUX_PKT_LOCK_EN
                out_last <= in_last[grant];
                // Lock only tracks round-robin packets; manual traffic leaves it alone.
                if (mode) begin
                    lock    <= !in_last[grant];
                    lock_ch <= grant;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Bench for mux_rr_nx1: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_mux_rr_nx1;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int SW  = 2;
    localparam int N6  = 6;
    localparam int SW6 = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;

    logic            mode6;
    logic [SW6-1:0]  sel6;
    logic [N6*W-1:0] in_data6;
    logic [N6-1:0]   in_valid6;
    logic [N6-1:0]   in_ready6;
    logic [W-1:0]    out_data6;
    logic [SW6-1:0]  out_ch6;
    logic            out_valid6;
    logic            out_ready6;
`ifdef MUX_PKT_LOCK_EN
    logic [N-1:0]    in_last;
    logic            out_last;
    logic [N6-1:0]   in_last6;
    logic            out_last6;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: what the output register must hold.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;
    logic         m_last;
    logic         m_lock;
    int           m_lock_ch;

    always #5 clk = ~clk;

    mux_rr_nx1 #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef MUX_PKT_LOCK_EN
        .in_last(in_last), .out_last(out_last),
`endif
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_rr_nx1 #(.WIDTH(W), .CHANNELS(N6), .SEL_W(SW6)) u_dut6 (
        .clk(clk), .rst(rst), .mode(mode6), .sel(sel6),
        .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
`ifdef MUX_PKT_LOCK_EN
        .in_last(in_last6), .out_last(out_last6),
`endif
        .out_data(out_data6), .out_ch(out_ch6), .out_valid(out_valid6), .out_ready(out_ready6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_ch      = 0;
        m_ptr     = N - 1;
        m_last    = 1'b0;
        m_lock    = 1'b0;
        m_lock_ch = 0;
    endtask

    // Grant rule: manual picks sel if valid; round-robin picks the first valid channel after ptr.
    function automatic void mgrant(output logic hit, output int g);
        hit = 1'b0;
        g   = 0;
        if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) begin
                hit = 1'b1;
                g   = int'(sel);
            end
        end else if (m_lock) begin
            hit = in_valid[m_lock_ch];
            g   = m_lock_ch;
        end else begin
            for (int s = 1; s <= N; s++) begin
                int k;
                k = (m_ptr + s) % N;
                if (!hit && in_valid[k]) begin
                    hit = 1'b1;
                    g   = k;
                end
            end
        end
    endfunction

    function automatic logic [W-1:0] chan_data(input int k);
        logic [N*W-1:0] v;
        v = in_data >> (k * W);
        return v[W-1:0];
    endfunction

    // One clock: inputs already driven after a negedge; checks in_ready, then the registered outputs.
    task automatic step();
        logic         hit;
        int           g;
        logic         load;
        logic [N-1:0] exp_rdy;
        #1;
        mgrant(hit, g);
        load    = !m_valid || out_ready;
        exp_rdy = '0;
        if (hit && load) exp_rdy = N'(1) << g;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (load) begin
            m_valid = hit;
            if (hit) begin
                m_data = chan_data(g);
                m_ch   = g;
                if (mode) m_ptr = g;
`ifdef MUX_PKT_LOCK_EN
                m_last = in_last[g];
                if (mode) begin
                    m_lock    = !in_last[g];
                    m_lock_ch = g;
                end
`endif
            end
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_ch", 32'(out_ch), 32'(m_ch));
`ifdef MUX_PKT_LOCK_EN
        chk("out_last", 32'(out_last), 32'(m_last));
`endif
    endtask

    task automatic set_data(input logic [W-1:0] base);
        for (int k = 0; k < N; k++) in_data[k*W +: W] = base + W'(k);
    endtask

    initial begin
        mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b1;
        mode6 = 1'b0; sel6 = '0; in_data6 = '0; in_valid6 = '0; out_ready6 = 1'b1;
`ifdef MUX_PKT_LOCK_EN
        in_last = '1;
        in_last6 = '1;
`endif
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Six-channel instance: selects 6 and 7 are out of range and never grant.
        for (int k = 0; k < N6; k++) in_data6[k*W +: W] = 8'h60 + W'(k);
        in_valid6 = '1;
        sel6 = 3'd6;
        #1 chk("sel6_rdy", 32'(in_ready6), 32'd0);
        @(negedge clk);
        chk("sel6_out_valid", 32'(out_valid6), 32'd0);
        sel6 = 3'd5;
        #1 chk("sel5_rdy", 32'(in_ready6), 32'h20);
        @(negedge clk);
        chk("sel5_out_ch", 32'(out_ch6), 32'd5);
        chk("sel5_out_data", 32'(out_data6), 32'h65);
        sel6 = 3'd7;
        #1 chk("sel7_rdy", 32'(in_ready6), 32'd0);
        @(negedge clk);
        chk("sel7_out_valid", 32'(out_valid6), 32'd0);
        mode6 = 1'b1;
        #1 chk("rr6_first_rdy", 32'(in_ready6), 32'd1);
        @(negedge clk);
        chk("rr6_first_ch", 32'(out_ch6), 32'd0);
        in_valid6 = '0;

        // Manual select of channel 2, then a select whose channel is idle.
        mode = 1'b0; sel = 2'd2; in_data[2*W +: W] = 8'hA5; in_valid = 4'b0100;
        #1 chk("man_rdy", 32'(in_ready), 32'b0100);
        step();
        chk("man_data", 32'(out_data), 32'hA5);
        chk("man_ch", 32'(out_ch), 32'd2);
        chk("man_valid", 32'(out_valid), 32'd1);
        sel = 2'd3;
        step();
        chk("man_idle_valid", 32'(out_valid), 32'd0);

        // Round-robin fairness with all channels valid, then every other channel.
        mode = 1'b1; in_valid = 4'b1111; set_data(8'h10);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_ch", 32'(out_ch), 32'(i % 4));
            chk("rr_data", 32'(out_data), 32'h10 + 32'(i % 4));
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_alt_ch", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Backpressure: a held beat of 8'h33 survives changing inputs.
        mode = 1'b0; sel = 2'd0; in_data[0 +: W] = 8'h33; in_valid = 4'b0001;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode = 1'($urandom); sel = SW'($urandom); in_valid = N'($urandom);
            in_data = {$urandom, $urandom} >> 32;
            #1 chk("bp_rdy", 32'(in_ready), 32'd0);
            step();
            chk("bp_data", 32'(out_data), 32'h33);
        end
        out_ready = 1'b1; mode = 1'b1; in_valid = 4'b0100; in_data[2*W +: W] = 8'h44;
        #1 chk("bp_reload_rdy", 32'(in_ready), 32'b0100);
        step();
        chk("bp_reload_data", 32'(out_data), 32'h44);
        chk("bp_reload_valid", 32'(out_valid), 32'd1);

        // Idle drops out_valid without moving the pointer.
        in_valid = '0;
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        in_valid = 4'b1111;
        step();
        chk("idle_ptr_ch", 32'(out_ch), 32'd3);
        in_valid = 4'b1000;
        step();
        chk("ch3_only", 32'(out_ch), 32'd3);

        // Asynchronous reset with a beat held.
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_ch", 32'(out_ch), 32'd0);
        chk("mid_rst_rdy", 32'(in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 4'b1111; set_data(8'h20);
        step();
        chk("post_rst_ch", 32'(out_ch), 32'd0);

`ifdef MUX_PKT_LOCK_EN
        // Channel 1 holds the grant for its 3-beat packet while 0 and 2 wait.
        in_valid = 4'b0111; in_last = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) in_last[1] = 1'b1;
            step();
            chk("lock_ch", 32'(out_ch), 32'd1);
            chk("lock_last", 32'(out_last), (i == 2) ? 32'd1 : 32'd0);
        end
        step();
        chk("unlock_ch", 32'(out_ch), 32'd2);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            mode = ((c / 40) % 4) != 3;
            sel = SW'($urandom_range(0, N - 1));
            in_valid = N'($urandom);
            for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
`ifdef MUX_PKT_LOCK_EN
            in_last = N'($urandom);
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
